// File: rtl/conv3x3_stream_acc.sv
// Streaming single-channel 3x3 convolution: loads 9 signed weights, then slides a
// window over a raster-order unsigned 8-bit image and emits one 32-bit result per valid window.
module conv3x3_stream_acc #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  input  logic        bus_free,
  output logic        weight_ing,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        conv_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    LOAD_W,
    CONV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          wcnt;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic signed [7:0]   wt [9];
  logic [7:0]          lb_top [IMG_W];
  logic [7:0]          lb_mid [IMG_W];
  logic [7:0]          win [3][2];
  logic [7:0]          new_col [3];
  logic [7:0]          pix;
  logic                w_accept;
  logic                p_accept;
  logic                last_col;
  logic                last_row;
  logic                win_full;
  logic signed [31:0]  acc;
  logic                unused_hi;

  assign pix        = data_i[7:0];
  assign unused_hi  = ^data_i[31:8];
  assign weight_ing = (state_q == LOAD_W);
  assign w_accept   = (state_q == LOAD_W) && valid_i;
  assign p_accept   = (state_q == CONV) && valid_i && bus_free;
  assign last_col   = (col == CW'(IMG_W - 1));
  assign last_row   = (row == RW'(IMG_H - 1));
  assign win_full   = (row >= RW'(2)) && (col >= CW'(2));

  // Signed weight times zero-extended pixel, widened to the accumulator width.
  function automatic logic signed [31:0] mac(input logic signed [7:0] w, input logic [7:0] p);
    logic signed [16:0] prod;
    prod = w * $signed({1'b0, p});
    return 32'(prod);
  endfunction

  always_comb begin
    new_col[0] = lb_top[col];
    new_col[1] = lb_mid[col];
    new_col[2] = pix;
  end

  // The rightmost window column is the incoming pixel plus the two rows above it,
  // so a result is ready combinationally on the accepting cycle.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      acc = acc + mac(wt[i*3+0], win[i][0])
                + mac(wt[i*3+1], win[i][1])
                + mac(wt[i*3+2], new_col[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_W: if (w_accept && (wcnt == 4'd8)) state_d = CONV;
      CONV:   if (p_accept && last_row && last_col) state_d = DONE;
      DONE:   state_d = LOAD_W;
      default: state_d = LOAD_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= LOAD_W;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wcnt <= '0;
      for (int k = 0; k < 9; k++) wt[k] <= '0;
    end else if (w_accept) begin
      wt[wcnt] <= $signed(pix);
      wcnt     <= (wcnt == 4'd8) ? 4'd0 : wcnt + 4'd1;
    end
  end

  // Counters wrap to zero on the final pixel, so the next frame starts clean.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col <= '0;
      row <= '0;
    end else if (p_accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < IMG_W; k++) begin
        lb_top[k] <= '0;
        lb_mid[k] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) win[i][j] <= '0;
      end
    end else if (p_accept) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pix;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= new_col[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_o    <= '0;
      valid_o   <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      valid_o   <= p_accept && win_full;
      conv_done <= p_accept && last_row && last_col;
      if (p_accept && win_full) data_o <= acc;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_acc.sv
// Randomized scoreboard bench for conv3x3_stream_acc: a driver feeds frames and queues
// expected results from an image-array reference model; a monitor checks every output.
module tb_conv3x3_stream_acc;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int HALF  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        bus_free = 1'b0;
  logic        weight_ing;
  logic [31:0] data_o;
  logic        valid_o;
  logic        conv_done;

  conv3x3_stream_acc #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .bus_free(bus_free),
    .weight_ing(weight_ing), .data_o(data_o), .valid_o(valid_o), .conv_done(conv_done)
  );

  always #HALF clk = ~clk;

  typedef struct {
    logic [31:0] val;
    bit          last;
    time         due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  // Reference model state: phase 0 = weights, 1 = image, 2 = done cycle
  int                m_phase = 0;
  int                m_wn = 0;
  int                m_r = 0;
  int                m_c = 0;
  logic signed [7:0] m_w [9];
  int                m_img [IMG_H][IMG_W];
  logic [7:0]        wset [9];

  // Monitor-side bookkeeping
  logic [31:0] last_data = '0;
  int          res_cnt = 0;
  int          frame_results = 0;
  int          done_count = 0;
  logic [31:0] first_res = '0;
  logic [31:0] done_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] window_sum(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(m_w[i*3+j]) * m_img[r-2+i][c-2+j];
    return 32'(s);
  endfunction

  task automatic model_step(input bit v, input logic [7:0] d, input bit bf);
    exp_t e;
    bit   fin;
    case (m_phase)
      0: if (v) begin
        m_w[m_wn] = $signed(d);
        m_wn++;
        if (m_wn == 9) begin
          m_wn = 0; m_r = 0; m_c = 0; m_phase = 1;
        end
      end
      1: if (v && bf) begin
        m_img[m_r][m_c] = int'(d);
        fin = (m_r == IMG_H-1) && (m_c == IMG_W-1);
        if (m_r >= 2 && m_c >= 2) begin
          e.val  = window_sum(m_r, m_c);
          e.last = fin;
          e.due  = $time + HALF;
          sb.push_back(e);
        end
        if (m_c == IMG_W-1) begin
          m_c = 0;
          m_r++;
        end else begin
          m_c++;
        end
        if (fin) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit bf);
    logic [31:0] rnd;
    @(negedge clk);
    check("weight_ing", 32'(weight_ing), 32'(m_phase == 0));
    rnd      = $urandom;
    valid_i  = v;
    data_i   = {rnd[31:8], d};
    bus_free = bf;
    @(posedge clk);
    model_step(v, d, bf);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    check("queue_empty_at_reset", 32'(sb.size()), 32'd0);
    rst_n   = 1'b1;
    valid_i = 1'b0;
    m_phase = 0; m_wn = 0; m_r = 0; m_c = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_weight_ing", 32'(weight_ing), 32'd1);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_conv_done", 32'(conv_done), 32'd0);
    check("rst_data_o", data_o, 32'd0);
    #1;
    rst_n = 1'b0;
  endtask

  function automatic logic [7:0] pixel_for(input int mode, input int r, input int c);
    case (mode)
      0: return 8'(r * IMG_W + c);
      1: return 8'd1;
      2: return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  // bp: 0 = bus always free, 1 = bus_free toggles each cycle
  task automatic run_frame(input int pmode, input bit bp, input int max_px);
    bit tog = 1'b1;
    int sent = 0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, wset[k], bp ? tog : 1'b1);
      tog = ~tog;
    end
    while (m_phase == 1 && sent < max_px) begin
      if (!bp || tog) sent++;
      applyStimulus(1'b1, pixel_for(pmode, m_r, m_c), bp ? tog : 1'b1);
      tog = ~tog;
    end
    if (m_phase == 2) applyStimulus(1'b1, 8'($urandom), 1'b1);
  endtask

  task automatic checkOutput(input string name, input int done_before, input logic [31:0] last_req);
    check({name, "_done_cnt"}, 32'(done_count), 32'(done_before + 1));
    check({name, "_results"}, 32'(frame_results), 32'((IMG_W-2)*(IMG_H-2)));
    check({name, "_last"}, done_res, last_req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      last_data = '0;
      res_cnt   = 0;
    end else if (valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_valid_o: got data %0h expected no result at %0t", data_o, $time);
      end else begin
        e = sb.pop_front();
        check("result", data_o, e.val);
        check("latency", 32'($time), 32'(e.due));
        check("conv_done", 32'(conv_done), 32'(e.last));
        last_data = e.val;
        if (res_cnt == 0) first_res = data_o;
        res_cnt++;
        if (conv_done) begin
          done_res      = data_o;
          frame_results = res_cnt;
          done_count++;
          res_cnt = 0;
        end
      end
    end else begin
      check("conv_done_idle", 32'(conv_done), 32'd0);
      check("data_hold", data_o, last_data);
      if (sb.size() > 0 && sb[0].due <= $time) begin
        checks++;
        $display("[TB] FAIL missing_result: got no valid_o expected %0h at %0t", sb[0].val, $time);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int d0;
    do_reset(3);
    repeat (3) applyStimulus(1'b0, 8'($urandom), 1'b1);

    foreach (wset[k]) wset[k] = (k == 4) ? 8'd1 : 8'd0;
    d0 = done_count;
    run_frame(0, 1'b0, 1000);
    checkOutput("identity", d0, 32'd54);
    check("identity_first", first_res, 32'd9);

    foreach (wset[k]) wset[k] = 8'd1;
    d0 = done_count;
    run_frame(1, 1'b0, 1000);
    checkOutput("sum_ones", d0, 32'd9);

    foreach (wset[k]) wset[k] = 8'hFF;
    d0 = done_count;
    run_frame(2, 1'b0, 1000);
    checkOutput("sum_neg", d0, 32'hFFFFF709);

    foreach (wset[k]) wset[k] = (k == 4) ? 8'd1 : 8'd0;
    d0 = done_count;
    run_frame(0, 1'b1, 1000);
    checkOutput("backpressure", d0, 32'd54);
    check("bp_first", first_res, 32'd9);

    for (int f = 0; f < 3; f++) begin
      foreach (wset[k]) wset[k] = 8'($urandom);
      d0 = done_count;
      run_frame(3, 1'b0, 1000);
      check("random_done_cnt", 32'(done_count), 32'(d0 + 1));
      check("random_results", 32'(frame_results), 32'((IMG_W-2)*(IMG_H-2)));
    end

    foreach (wset[k]) wset[k] = 8'($urandom);
    d0 = done_count;
    run_frame(3, 1'b0, 20);
    repeat (2) applyStimulus(1'b0, 8'd0, 1'b1);
    do_reset(1);
    check("midreset_no_done", 32'(done_count), 32'(d0));

    foreach (wset[k]) wset[k] = 8'($urandom);
    d0 = done_count;
    run_frame(3, 1'b0, 1000);
    check("post_reset_done_cnt", 32'(done_count), 32'(d0 + 1));
    check("post_reset_results", 32'(frame_results), 32'((IMG_W-2)*(IMG_H-2)));

    repeat (4) applyStimulus(1'b0, 8'd0, 1'b1);
    check("queue_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream_acc.md
Name: conv3x3_stream_acc

Overview:
Streaming single-channel 3x3 convolution accelerator for the VGG-style inference SoC. It sits between the system bus input FIFO and the result write-back path. Each frame first loads 9 kernel weights, then consumes a raster-order image and emits one 32-bit result per valid (unpadded) window position. It signals frame completion with conv_done and then returns to weight loading.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-high (asserted = 1) despite the suffix
data_i  in  32  input word; weight phase: [7:0] = signed 8-bit weight; image phase: [7:0] = unsigned 8-bit pixel; [31:8] ignored
valid_i  in  1  data_i valid this cycle
bus_free  in  1  downstream able to take a result this cycle (output back-pressure)
weight_ing  out  1  high while the block is in the weight-load phase
data_o  out  32  signed 32-bit convolution result
valid_o  out  1  data_o valid this cycle (single-cycle strobe per result)
conv_done  out  1  one-cycle pulse marking the last result of a frame

Behaviour:
- Reset (rst_n=1 at a clk edge): state=LOAD_W, weight count=0, row/col counters=0, window/line buffers cleared. Outputs: weight_ing=1 (follows state), data_o=0, valid_o=0, conv_done=0. Reset mid-frame aborts the frame; no partial conv_done.
- States: LOAD_W -> CONV -> DONE -> LOAD_W.
- LOAD_W: weight_ing=1. Word accepted when valid_i=1 (bus_free ignored). Weights stored in order w0..w8 = kernel (0,0),(0,1),(0,2),(1,0)...(2,2), row-major. After 9th accept -> CONV next cycle.
- CONV: weight_ing=0. Pixel accepted only when valid_i=1 AND bus_free=1; otherwise the cycle is ignored (no counter or buffer change). Pixels arrive raster order, row r=0..IMG_H-1, col c=0..IMG_W-1.
- Two line buffers of IMG_W pixels plus a 3x3 window register hold the previous two rows.
- Accepting pixel (r,c) with r>=2 and c>=2 completes window with top-left (r-2,c-2). Result = sum over i,j of w[i*3+j] * pixel(r-2+i, c-2+j), pixel zero-extended to 9 bits, weight signed, products sign-extended to 32 bits. No saturation or shift. Range fits easily in 32 bits.
- Latency: data_o/valid_o registered, asserted exactly 1 cycle after the accepting edge. valid_o=0 on all other cycles. data_o holds its last value when valid_o=0.
- Results per frame: (IMG_W-2)*(IMG_H-2), in raster order of window position. No padding.
- Accepting pixel (IMG_H-1,IMG_W-1) moves the state to DONE. In DONE (one cycle): valid_o=1 with last result, conv_done=1, no input accepted. Next cycle: LOAD_W, counters cleared, weights must be reloaded.
- bus_free only gates acceptance. Because results are produced only on accepting cycles, no output buffering is needed and results are never dropped.
- Row wrap: col resets to 0 and row increments after col=IMG_W-1. Window columns from the previous row's tail never combine with the new row, because results are suppressed for c<2.

Test Plan:
- Reset then idle: rst_n=1 for 3 cycles, valid_i=0 -> weight_ing=1, valid_o=0, conv_done=0, data_o=0.
- Identity kernel: weights 0,0,0,0,1,0,0,0,0, then pixels value r*8+c (8x8), bus_free=1 -> 36 results; first = 9, last = 54; each 1 cycle after its pixel. conv_done coincides with the 36th valid_o; weight_ing=1 the next cycle.
- Sum kernel: all weights 1, all pixels 1 -> every result 9. All weights -1 (0xFF), all pixels 255 -> every result 0xFFFFF709 (-2295).
- Back-pressure: toggle bus_free 1/0 each cycle with continuous valid_i -> same 36 results in order. No acceptance or valid_o on bus_free=0 cycles. Weight load completes regardless of bus_free.
- Continuous random traffic (valid_i=bus_free=1, random data) for 3 frames -> per frame: 9 cycles weight_ing=1, 64 accepts, 36 valid_o, one conv_done. Results match the reference model.
- Reset mid-frame after 20 pixels -> next cycle LOAD_W, no conv_done. A fresh frame then produces correct results.
